queue_ctrl: RTL and testbench

- Control block between the serial front end and the 8-entry word queue in TOP.
- Samples the `write_in` / `data_in` bit stream and assembles bytes MSB-first.
- Issues single-cycle enqueue and dequeue strobes to the queue.
- Drives `status_out` to tell the sender when a new byte may be sent, and flags protocol errors.

---
 rtl/queue_pkg.sv | 19 +
 rtl/queue_ctrl_edge_sync.sv | 28 ++
 rtl/queue_ctrl.sv | 143 ++++++++++++++
 tb/tb_queue_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared types and constants for the serial-to-queue controller.
// Word, queue and timeout sizing live here so all blocks agree.
package queue_pkg;

  localparam int WORD_W  = 8;
  localparam int DEPTH   = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 50000;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = $clog2(WORD_W);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SHIFT,
    S_ENQ,
    S_GAP
  } state_t;

endpackage

// File: rtl/queue_ctrl_edge_sync.sv
// Two-flop synchroniser with a history flop; pulses on a 0->1 edge.
// Edge appears two clocks after the input rises, acted on at the third.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~hist_q;

endmodule

// File: rtl/queue_ctrl.sv
// Assembles serial bits into bytes MSB-first and strobes the word queue.
// Dequeue requests are held pending until the FSM can issue them safely.
module queue_ctrl
  import queue_pkg::*;
(
  input  logic              clock_1MHz,
  input  logic              rst,
  input  logic              data_in,
  input  logic              write_in,
  input  logic              dequeue_in,
  input  logic [LEN_W-1:0]  q_len_i,
  output logic              enq_o,
  output logic              deq_o,
  output logic [WORD_W-1:0] word_o,
  output logic              status_out,
  output logic              ovf_o,
  output logic              unf_o,
  output logic              tmo_o
);

  logic              wr_rise;
  logic              dq_rise;
  logic [1:0]        din_q;
  state_t            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              pend_q;

  logic not_full;
  logic empty;
  logic word_done;
  logic pend;
  logic serve;
  logic idle_st;

  edge_sync u_wr_sync (
    .clk_i  (clock_1MHz),
    .rst_i  (rst),
    .d_i    (write_in),
    .rise_o (wr_rise)
  );

  edge_sync u_dq_sync (
    .clk_i  (clock_1MHz),
    .rst_i  (rst),
    .d_i    (dequeue_in),
    .rise_o (dq_rise)
  );

  // data shares the write strobe's synchroniser depth so they stay aligned
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      din_q <= 2'b00;
    end else begin
      din_q <= {din_q[0], data_in};
    end
  end

  assign shift_d   = {shift_q[WORD_W-2:0], din_q[1]};
  assign not_full  = q_len_i < LEN_W'(DEPTH);
  assign empty     = q_len_i == '0;
  assign idle_st   = (state_q == S_WAIT) || (state_q == S_SHIFT);
  assign word_done = (state_q == S_SHIFT) && wr_rise
                     && (cnt_q == CNT_W'(WORD_W - 1));
  assign pend      = pend_q | dq_rise;
  // a completing word owns the next strobe slot, so hold the dequeue
  assign serve     = pend && idle_st && !deq_o && !word_done;

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      pend_q     <= 1'b0;
      enq_o      <= 1'b0;
      deq_o      <= 1'b0;
      word_o     <= '0;
      status_out <= 1'b0;
      ovf_o      <= 1'b0;
      unf_o      <= 1'b0;
      tmo_o      <= 1'b0;
    end else begin
      enq_o      <= 1'b0;
      deq_o      <= 1'b0;
      ovf_o      <= 1'b0;
      unf_o      <= 1'b0;
      tmo_o      <= 1'b0;
      status_out <= idle_st && not_full && !enq_o && !deq_o;
      pend_q     <= pend & ~serve;
      if (serve) begin
        if (empty) begin
          unf_o <= 1'b1;
        end else begin
          deq_o <= 1'b1;
        end
      end
      unique case (state_q)
        S_WAIT: begin
          tmr_q <= '0;
          if (wr_rise) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (wr_rise) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 1'b1;
            tmr_q   <= '0;
            if (word_done) begin
              state_q <= S_ENQ;
            end
          end else if (tmr_q == TMR_W'(TIMEOUT)) begin
            tmo_o   <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_ENQ: begin
          if (not_full) begin
            enq_o  <= 1'b1;
            word_o <= shift_q;
          end else begin
            ovf_o <= 1'b1;
          end
          state_q <= S_GAP;
        end
        S_GAP: begin
          state_q <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// Scoreboard bench: a word-level queue model predicts strobe/error events,
// a negedge monitor pops and compares them and emulates the word queue.
`timescale 1ns/1ps
module tb_queue_ctrl;
  import queue_pkg::*;

  localparam int K_ENQ = 0;
  localparam int K_DEQ = 1;
  localparam int K_OVF = 2;
  localparam int K_UNF = 3;
  localparam int K_TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in = 1'b0;
  logic write_in = 1'b0;
  logic dequeue_in = 1'b0;
  logic [LEN_W-1:0] q_len = '0;
  logic enq_o, deq_o, status_out, ovf_o, unf_o, tmo_o;
  logic [WORD_W-1:0] word_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int enq_cyc = 0;
  int deq_cyc = 0;

  logic [7:0] mq[$];
  logic [7:0] dq[$];
  int exp_k[$];
  logic [7:0] exp_w[$];

  queue_ctrl dut (
    .clock_1MHz (clk),
    .rst        (rst),
    .data_in    (data_in),
    .write_in   (write_in),
    .dequeue_in (dequeue_in),
    .q_len_i    (q_len),
    .enq_o      (enq_o),
    .deq_o      (deq_o),
    .word_o     (word_o),
    .status_out (status_out),
    .ovf_o      (ovf_o),
    .unf_o      (unf_o),
    .tmo_o      (tmo_o)
  );

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  function automatic void expect_ev(int k, logic [7:0] w);
    exp_k.push_back(k);
    exp_w.push_back(w);
  endfunction

  function automatic void take(int k, logic [7:0] w);
    int ek;
    logic [7:0] ew;
    if (exp_k.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected event: got kind %0d want none", k);
      return;
    end
    ek = exp_k.pop_front();
    ew = exp_w.pop_front();
    chk("event kind", k, ek);
    if (k == ek && (k == K_ENQ || k == K_DEQ))
      chk("event word", int'(w), int'(ew));
  endfunction

  // monitor plus emulation of the word queue feeding q_len back
  always @(negedge clk) begin
    logic [7:0] pw;
    if (!rst) begin
      if (enq_o) begin
        enq_cyc = cyc;
        take(K_ENQ, word_o);
        dq.push_back(word_o);
      end
      if (deq_o) begin
        deq_cyc = cyc;
        pw = 8'h00;
        if (dq.size() != 0) pw = dq.pop_front();
        take(K_DEQ, pw);
      end
      if (ovf_o) take(K_OVF, 8'h00);
      if (unf_o) take(K_UNF, 8'h00);
      if (tmo_o) take(K_TMO, 8'h00);
      q_len = LEN_W'(dq.size());
    end
  end

  task automatic send_bit(input logic b, input bit col);
    @(negedge clk);
    data_in = b;
    write_in = 1'b1;
    if (col) dequeue_in = 1'b1;
    wr_cyc = cyc;
    repeat (10) @(negedge clk);
    write_in = 1'b0;
    dequeue_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic model_deq();
    if (mq.size() != 0) expect_ev(K_DEQ, mq.pop_front());
    else expect_ev(K_UNF, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] w, input bit col);
    if (mq.size() < DEPTH) begin
      mq.push_back(w);
      expect_ev(K_ENQ, w);
    end else begin
      expect_ev(K_OVF, 8'h00);
    end
    if (col) model_deq();
    for (int i = 7; i >= 0; i--) send_bit(w[i], col && i == 0);
  endtask

  task automatic deq_pulse(input int hi, input int lo);
    model_deq();
    @(negedge clk);
    dequeue_in = 1'b1;
    repeat (hi) @(negedge clk);
    dequeue_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_k.size() != 0; i++) @(negedge clk);
    chk("pending events drained", exp_k.size(), 0);
  endtask

  initial begin
    #1200;
    chk("reset enq", int'(enq_o), 0);
    chk("reset deq", int'(deq_o), 0);
    chk("reset word", int'(word_o), 0);
    chk("reset status", int'(status_out), 0);
    chk("reset err", int'({ovf_o, unf_o, tmo_o}), 0);
    #1300;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("status after reset", int'(status_out), 1);

    send_byte(8'h81, 1'b0);
    drain();
    chk("enq latency 3..5", int'(enq_cyc - wr_cyc >= 3 && enq_cyc - wr_cyc <= 5), 1);

    deq_pulse(5, 20);
    drain();
    for (int b = 0; b < 8; b++) send_byte(8'h80 + 8'(b), 1'b0);
    drain();
    chk("len when full", int'(q_len), 8);
    repeat (3) @(negedge clk);
    chk("status when full", int'(status_out), 0);
    send_byte(8'h88, 1'b0);
    drain();
    chk("len after overflow", int'(q_len), 8);

    for (int i = 0; i < 4; i++) deq_pulse(200, 600);
    drain();
    chk("len after 4 deq", int'(q_len), 4);
    chk("status after deq", int'(status_out), 1);

    for (int i = 0; i < 5; i++) deq_pulse(5, 20);
    drain();
    chk("len after underflow", int'(q_len), 0);

    send_byte(8'h5A, 1'b1);
    drain();
    chk("deq >=2 after enq", int'(deq_cyc - enq_cyc >= 2), 1);

    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    expect_ev(K_TMO, 8'h00);
    repeat (TIMEOUT + 5) @(negedge clk);
    drain();
    send_byte(8'hC3, 1'b0);
    drain();
    chk("len after timeout word", int'(q_len), 1);

    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h3C, 1'b0);
    drain();
    chk("len after reset word", int'(q_len), 2);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) deq_pulse(5, 15);
      else send_byte(8'($urandom), 1'b0);
    end
    drain();
    chk("final len", dq.size(), mq.size());
    for (int i = 0; i < dq.size() && i < mq.size(); i++)
      chk("final content", int'(dq[i]), int'(mq[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
